// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined-adder result collector.
// Optional statistics counters are enabled by defining COLLECT_STATS_EN.
package pipe_adder_pkg;

  localparam int ADD_W       = 16;  // adder sum width
  localparam int ADD_LATENCY = 2;   // adder cycles from operand edge to S/cout
  localparam int FIFO_DEPTH  = 4;   // default result buffer depth

  // One adder result as it is buffered and presented downstream.
  typedef struct packed {
    logic             cout;
    logic [ADD_W-1:0] sum;
  } result_t;

  // Ceiling log2 with a floor of 1 so that a 1-bit pointer/counter is the minimum.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipe_adder_collector_if.sv
// Bus bundle between the adder feeder, the collector and the result consumer.
// res_cnt/carry_cnt exist only when COLLECT_STATS_EN is defined.
interface pipe_adder_collector_if
  import pipe_adder_pkg::*;
#(
  parameter int W = ADD_W
);
  // issue side
  logic         issue_valid;
  logic         issue_ready;
  logic [W-1:0] add_s;
  logic         add_cout;
  // result side
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  // status
  logic         drop_err;
`ifdef COLLECT_STATS_EN
  logic [15:0]  res_cnt;
  logic [15:0]  carry_cnt;
`endif

  // collector's view
  modport slave (
    input  issue_valid, add_s, add_cout, out_ready,
    output issue_ready, out_valid, out_sum, out_cout, drop_err
`ifdef COLLECT_STATS_EN
    , output res_cnt, carry_cnt
`endif
  );

  // feeder/consumer view
  modport master (
    output issue_valid, add_s, add_cout, out_ready,
    input  issue_ready, out_valid, out_sum, out_cout, drop_err
`ifdef COLLECT_STATS_EN
    , input res_cnt, carry_cnt
`endif
  );

endinterface

// File: rtl/pipe_result_fifo.sv
// Small result FIFO with a registered head word; async active-low reset.
// The head register holds its last value when the FIFO drains empty.
module pipe_result_fifo
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = ADD_W + 1,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_o,
  output logic [clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign rd_next = rd_ptr_q + PTR_W'(1);

  // Next pointers/count, and the word that becomes head after this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_next;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    // A push lands directly in the head register when nothing older remains.
    if (do_push && ((count_q == '0) || ((count_q == CNT_W'(1)) && do_pop))) begin
      head_d = push_data_i;
    end else if (do_pop && (count_q > CNT_W'(1))) begin
      head_d = mem[rd_next];
    end
  end

  // Storage array, written at the tail; no reset needed on the data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  // Pointer, count and head state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/pipe_adder_collector.sv
// Downstream stage of the pipelined adder: tracks issued slots with a valid
// chain, captures S/cout into a result FIFO and grants issue credits so the
// FIFO can never overflow. Statistics counters appear with COLLECT_STATS_EN.
module pipe_adder_collector
  import pipe_adder_pkg::*;
#(
  parameter int W       = ADD_W,
  parameter int LATENCY = ADD_LATENCY,
  parameter int DEPTH   = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_adder_collector_if.slave bus
);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int SUM_W = clog2(DEPTH + LATENCY + 1) + 1;

  logic [LATENCY-1:0] vchain_q, vchain_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   inflight;
  logic [SUM_W-1:0]   committed;
  logic [W:0]         head;
  logic               issue_ready;
  logic               issue_fire;
  logic               capture;
  logic               pop;
  logic               drop_err_q, drop_err_d;

  assign issue_fire = bus.issue_valid && issue_ready;
  assign capture    = vchain_q[LATENCY-1];
  assign pop        = bus.out_valid && bus.out_ready;

  // Shift a 1 into the chain for each accepted issue.
  generate
    if (LATENCY == 1) begin : g_chain_one
      assign vchain_d = issue_fire;
    end else begin : g_chain_multi
      assign vchain_d = {vchain_q[LATENCY-2:0], issue_fire};
    end
  endgenerate

  // Credits: results in flight plus results buffered must stay within DEPTH.
  // A same-cycle pop is deliberately not credited back.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SUM_W'(vchain_q[i]);
    end
    committed   = SUM_W'(fifo_count) + inflight;
    issue_ready = committed < SUM_W'(DEPTH);
  end

  // Sticky error for issues offered without a credit (those are not tracked).
  always_comb begin
    drop_err_d = drop_err_q | (bus.issue_valid & ~issue_ready);
  end

  // Valid chain and drop flag state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vchain_q   <= '0;
      drop_err_q <= 1'b0;
    end else begin
      vchain_q   <= vchain_d;
      drop_err_q <= drop_err_d;
    end
  end

  pipe_result_fifo #(
    .WIDTH (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (capture),
    .push_data_i ({bus.add_cout, bus.add_s}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign bus.issue_ready = issue_ready;
  assign bus.out_valid   = (fifo_count != '0);
  assign bus.out_sum     = head[W-1:0];
  assign bus.out_cout    = head[W];
  assign bus.drop_err    = drop_err_q;

`ifdef COLLECT_STATS_EN
  logic [15:0] res_cnt_q, res_cnt_d;
  logic [15:0] carry_cnt_q, carry_cnt_d;

  // Count delivered results and those carrying out; both wrap.
  always_comb begin
    res_cnt_d   = res_cnt_q;
    carry_cnt_d = carry_cnt_q;
    if (pop) begin
      res_cnt_d = res_cnt_q + 16'd1;
      if (head[W]) carry_cnt_d = carry_cnt_q + 16'd1;
    end
  end

  // Statistics counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_cnt_q   <= '0;
      carry_cnt_q <= '0;
    end else begin
      res_cnt_q   <= res_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign bus.res_cnt   = res_cnt_q;
  assign bus.carry_cnt = carry_cnt_q;
`endif

endmodule

// File: doc/pipe_adder_collector.md
Name: pipe_adder_collector

Overview:
Downstream stage of the 16-bit pipelined adder.
- Tracks which adder issue slots carry valid operands, using a valid shift chain matched to the adder latency.
- Captures S/cout when a tracked result emerges and buffers it in a small FIFO.
- Presents results on a valid/ready output interface.
- Returns an issue_ready credit so the upstream feeder never launches more operations than the FIFO can absorb.

Parameters:
- W, 16, data width of adder sum
- LATENCY, 2, adder clock cycles from operand edge to S/cout valid (>=1)
- DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- issue_valid  in  1  operands driven to adder this cycle are real
- issue_ready  out  1  credit available; issue accepted only when high
- add_s  in  W  adder sum output S
- add_cout  in  1  adder carry output
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer accepts head
- out_sum  out  W  head sum
- out_cout  out  1  head carry
- drop_err  out  1  sticky: issue_valid seen while issue_ready low
- [COLLECT_STATS_EN] res_cnt  out  16  results delivered
- [COLLECT_STATS_EN] carry_cnt  out  16  delivered results with cout=1

Behaviour:
- Reset (reset=0, async): valid chain=0, FIFO pointers/count=0, drop_err=0, counters=0. Outputs out_valid=0, out_sum=0, out_cout=0, issue_ready=1.
- Issue acceptance: issue_fire = issue_valid & issue_ready.
  - issue_fire shifts 1 into vchain[0]; otherwise 0 is shifted in.
  - vchain is LATENCY bits long.
- Credit accounting:
  - inflight = popcount(vchain).
  - issue_ready = (fifo_count + inflight) < DEPTH, combinational from registered state.
  - Same-cycle pop does not raise issue_ready; this conservative rule is required.
- Drop handling: issue_valid & !issue_ready sets drop_err (sticky until reset). The issue is not tracked.
- Capture: when vchain[LATENCY-1]=1 at a rising edge, {add_cout, add_s} is written to the FIFO tail.
  - Because of the credit rule, capture never finds the FIFO full.
  - End-to-end latency: issue edge -> out_valid high LATENCY+1 cycles later, if the FIFO was empty.
- Pop: out_valid & out_ready advances the head pointer.
  - out_sum/out_cout are registered head data, valid only when out_valid=1.
  - When empty, they hold their last value.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - If the FIFO is empty and a push occurs, the pushed entry becomes head next cycle. There is no bypass in the same cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- out_valid = (count != 0).
- Reset mid-operation discards in-flight and buffered results. Adder-internal state is ignored because vchain is cleared.
- Back-pressure: with out_ready=0 indefinitely, at most DEPTH results are accepted, then issue_ready stays 0.

Optional Feature:
- Macro COLLECT_STATS_EN.
  - Defined: res_cnt increments on each pop; carry_cnt increments on each pop with out_cout=1. Both wrap at 2^16 and reset to 0.
  - Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_adder_pkg holds:
  - ADD_W=16 and ADD_LATENCY constants
  - result struct/typedef {cout, sum[W-1:0]}
  - FIFO pointer width function clog2
- One natural sub-module: pipe_result_fifo. It is a synchronous DEPTH x (W+1) FIFO with push/pop/count and async active-low reset.
- Credit logic and the valid chain stay in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release.
  - Expect out_valid=0, issue_ready=1, drop_err=0, out_sum=0000.
- Single op: issue 0001+FFFF.
  - Expect out_valid after LATENCY+1 cycles with out_sum=0000, out_cout=1.
  - Pop with out_ready=1; out_valid returns to 0.
- Stream: issue 0002+FFFF, FFFF+0001, AAAA+AAAA, 0000+0000 back-to-back with out_ready=1.
  - Expect in-order results {1,0001}, {1,0000}, {1,5554}, {0,0000}.
  - No drop_err.
- Back-pressure: out_ready=0, issue_valid held high.
  - Exactly DEPTH=4 issues accepted; issue_ready falls after the 4th.
  - Further issue_valid sets drop_err=1.
  - Releasing out_ready drains the 4 results in order; drop_err stays 1.
- Reset mid-operation: 2 ops in flight plus 1 buffered, assert reset.
  - All cleared; no stale result appears after release.
  - issue_ready=1 immediately.
- With COLLECT_STATS_EN: after the stream test, expect res_cnt=4 and carry_cnt=3.
